// File: rtl/fetch_execute_sequencer_if.sv
// Memory and ALU bus between the fetch/execute sequencer (master) and
// the main memory / combinational ALU (slave).
interface fetch_execute_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, mem_we, mem_wdata, alu_opcode, alu_a, alu_b,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, alu_opcode, alu_a, alu_b,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/fetch_execute_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit accumulator
// machine; owns PC, IR and AC and sequences single-port memory and the ALU.
module fetch_execute_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic                       clk,
  input  logic                       reset,
  fetch_execute_sequencer_if.master  bus,
  output logic [11:0]                pc_out,
  output logic [15:0]                ir_out,
  output logic [15:0]                ac_out,
  output logic                       instr_done,
  output logic                       halted,
  output logic                       illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_RD, S_EXEC, S_WR, S_HALT
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ALU   = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;

  state_t      state;
  logic [11:0] pc;
  logic [15:0] ir;
  logic [15:0] ac;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [3:0]  alu_opcode;

  logic [3:0]  op;
  logic [11:0] addr;
  logic [11:0] pc_inc;
  logic [3:0]  fetched_op;

  assign op         = ir[15:12];
  assign addr       = (op == OP_ALU) ? {4'h0, ir[7:0]} : ir[11:0];
  assign pc_inc     = pc + 12'd1;
  assign fetched_op = bus.mem_rdata[15:12];

  // Bus outputs come from registers only; alu_b is the sole pass-through.
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = ac;
  assign bus.alu_opcode = alu_opcode;
  assign bus.alu_a      = ac;
  assign bus.alu_b      = bus.mem_rdata;

  assign pc_out = pc;
  assign ir_out = ir;
  assign ac_out = ac;

  // Outputs are registered for the state being entered, so each one is
  // already valid during the first cycle of that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      ac         <= 16'h0000;
      mem_addr   <= {4'h0, RESET_PC};
      mem_we     <= 1'b0;
      alu_opcode <= 4'h0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      alu_opcode <= 4'h0;
      instr_done <= 1'b0;
      case (state)
        S_FETCH: state <= S_FWAIT;
        S_FWAIT: begin
          ir    <= bus.mem_rdata;
          pc    <= pc_inc;
          // HALT and jumps retire in DECODE, so their pulse is armed here
          instr_done <= (fetched_op == OP_HALT) || (fetched_op == OP_JUMP) ||
                        (fetched_op == OP_JZ);
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            OP_LOAD, OP_ALU: begin
              mem_addr <= {4'h0, addr};
              state    <= S_RD;
            end
            OP_STORE: begin
              mem_addr   <= {4'h0, addr};
              mem_we     <= 1'b1;
              instr_done <= 1'b1;
              state      <= S_WR;
            end
            OP_JUMP: begin
              pc       <= addr;
              mem_addr <= {4'h0, addr};
              state    <= S_FETCH;
            end
            OP_JZ: begin
              if (ac == 16'h0000) begin
                pc       <= addr;
                mem_addr <= {4'h0, addr};
              end else begin
                mem_addr <= {4'h0, pc};
              end
              state <= S_FETCH;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_RD: begin
          if (op == OP_ALU) alu_opcode <= ir[11:8];
          instr_done <= 1'b1;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          ac       <= (op == OP_ALU) ? bus.alu_result : bus.mem_rdata;
          mem_addr <= {4'h0, pc};
          state    <= S_FETCH;
        end
        S_WR: begin
          mem_addr <= {4'h0, pc};
          state    <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Self-checking bench: two sequencers (RESET_PC 0x000 and 0xFFF) with their
// own memories, compared cycle by cycle against an instruction-level model.
module tb_fetch_execute_sequencer;

  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic loading = 1'b0;
  logic sel = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_execute_sequencer_if bus0();
  fetch_execute_sequencer_if bus1();

  logic [11:0] pc0, pc1;
  logic [15:0] ir0, ir1, ac0, ac1;
  logic        done0, done1, halted0, halted1, illegal0, illegal1;

  fetch_execute_sequencer #(.RESET_PC(12'h000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .pc_out(pc0), .ir_out(ir0),
    .ac_out(ac0), .instr_done(done0), .halted(halted0), .illegal(illegal0)
  );

  fetch_execute_sequencer #(.RESET_PC(12'hFFF)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .pc_out(pc1), .ir_out(ir1),
    .ac_out(ac1), .instr_done(done1), .halted(halted1), .illegal(illegal1)
  );

  logic [15:0] prog [4096];
  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];

  // ALU behaviour; division by zero yields 0xFFFF.
  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << 1;
      4'h7: return a >> 1;
      4'h8: return a * b;
      4'h9: return (b != 16'h0) ? a / b : 16'hFFFF;
      4'hA: return b;
      4'hB: return a;
      4'hC: return a + 16'd1;
      4'hD: return a - 16'd1;
      4'hE: return (a < b) ? 16'd1 : 16'd0;
      default: return (a == b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  assign bus0.alu_result = alu_fn(bus0.alu_opcode, bus0.alu_a, bus0.alu_b);
  assign bus1.alu_result = alu_fn(bus1.alu_opcode, bus1.alu_a, bus1.alu_b);

  always @(posedge clk) begin
    if (loading) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= prog[i];
        mem1[i] <= prog[i];
      end
    end else begin
      if (bus0.mem_we) mem0[bus0.mem_addr[11:0]] <= bus0.mem_wdata;
      if (bus1.mem_we) mem1[bus1.mem_addr[11:0]] <= bus1.mem_wdata;
    end
    bus0.mem_rdata <= mem0[bus0.mem_addr[11:0]];
    bus1.mem_rdata <= mem1[bus1.mem_addr[11:0]];
  end

  logic [11:0] s_pc;
  logic [15:0] s_ac, s_addr, s_wdata;
  logic [3:0]  s_aluop;
  logic        s_done, s_we, s_halted, s_illegal;
  assign s_pc      = sel ? pc1 : pc0;
  assign s_ac      = sel ? ac1 : ac0;
  assign s_addr    = sel ? bus1.mem_addr : bus0.mem_addr;
  assign s_wdata   = sel ? bus1.mem_wdata : bus0.mem_wdata;
  assign s_aluop   = sel ? bus1.alu_opcode : bus0.alu_opcode;
  assign s_done    = sel ? done1 : done0;
  assign s_we      = sel ? bus1.mem_we : bus0.mem_we;
  assign s_halted  = sel ? halted1 : halted0;
  assign s_illegal = sel ? illegal1 : illegal0;

  // Reference model: per-cycle expectations derived from the ISA rules.
  bit          exp_done [MAXC];
  bit          exp_we   [MAXC];
  bit          exp_fetch[MAXC];
  logic [11:0] exp_fetch_addr[MAXC];
  logic [15:0] exp_we_addr[MAXC];
  logic [15:0] exp_we_data[MAXC];
  logic [3:0]  exp_aluop[MAXC];
  logic [11:0] exp_pc[MAXC];
  logic [15:0] exp_ac[MAXC];
  logic [15:0] mm [4096];
  int          halt_cycle;
  bit          exp_ill;
  int          exp_retires;

  logic [15:0] obs_addr[MAXC];
  logic [11:0] obs_pc[MAXC];
  logic [3:0]  obs_aluop[MAXC];
  logic        obs_done[MAXC];
  int          obs_retires, obs_we_count, obs_halt_cycle;

  task automatic clear_prog;
    for (int i = 0; i < 4096; i++) prog[i] = 16'h0000;
  endtask

  task automatic run_model(input logic [11:0] start, input int n);
    logic [11:0] pc, npc, a;
    logic [15:0] ac, ir;
    logic [3:0]  op;
    int cyc, cpi, r;
    bit stop;
    for (int i = 0; i < MAXC; i++) begin
      exp_done[i] = 0; exp_we[i] = 0; exp_fetch[i] = 0; exp_fetch_addr[i] = '0;
      exp_we_addr[i] = '0; exp_we_data[i] = '0; exp_aluop[i] = '0;
      exp_pc[i] = '0; exp_ac[i] = '0;
    end
    for (int i = 0; i < 4096; i++) mm[i] = prog[i];
    halt_cycle = -1; exp_ill = 0; exp_retires = 0;
    cyc = 0; pc = start; ac = 16'h0; stop = 0;
    while (!stop) begin
      ir  = mm[pc];
      op  = ir[15:12];
      npc = pc + 12'd1;
      a   = ir[11:0];
      cpi = (op == 4'h1 || op == 4'h3) ? 5 : (op == 4'h2) ? 4 : 3;
      if (cyc + cpi > n) begin
        stop = 1;
      end else begin
        exp_fetch[cyc] = 1;
        exp_fetch_addr[cyc] = pc;
        r = cyc + cpi - 1;
        case (op)
          4'h0: begin pc = npc; halt_cycle = cyc + 3; stop = 1; end
          4'h1: begin ac = mm[a]; pc = npc; end
          4'h2: begin
            mm[a] = ac; exp_we[r] = 1; exp_we_addr[r] = {4'h0, a}; exp_we_data[r] = ac; pc = npc;
          end
          4'h3: begin
            exp_aluop[r] = ir[11:8];
            ac = alu_fn(ir[11:8], ac, mm[{4'h0, ir[7:0]}]);
            pc = npc;
          end
          4'h4: pc = a;
          4'h5: pc = (ac == 16'h0000) ? a : npc;
          default: begin pc = npc; halt_cycle = cyc + 3; exp_ill = 1; stop = 1; end
        endcase
        if (op <= 4'h5) begin
          exp_done[r] = 1; exp_pc[r] = pc; exp_ac[r] = ac; exp_retires++;
        end
        cyc = cyc + cpi;
      end
    end
  endtask

  task automatic load_and_release(input bit which);
    sel = which;
    reset = 1'b1;
    loading = 1'b1;
    @(posedge clk);
    #1 loading = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_and_check(input bit which, input logic [11:0] start, input int n, input string name);
    bit hexp;
    int bad;
    sel = which;
    reset = 1'b1;
    loading = 1'b1;
    @(posedge clk);
    #1 loading = 1'b0;
    run_model(start, n);
    @(negedge clk);
    reset = 1'b0;
    obs_retires = 0; obs_we_count = 0; obs_halt_cycle = -1;
    for (int c = 0; c < n; c++) begin
      obs_addr[c] = s_addr; obs_pc[c] = s_pc; obs_aluop[c] = s_aluop; obs_done[c] = s_done;
      if (s_done === 1'b1) obs_retires++;
      if (s_we === 1'b1) obs_we_count++;
      if (s_halted === 1'b1 && obs_halt_cycle < 0) obs_halt_cycle = c;
      hexp = (halt_cycle >= 0) && (c >= halt_cycle);
      checks++;
      if (s_done !== exp_done[c]) begin
        errors++; $display("[TB] FAIL %s instr_done cycle %0d: got %b expected %b", name, c, s_done, exp_done[c]);
      end
      checks++;
      if (s_we !== exp_we[c]) begin
        errors++; $display("[TB] FAIL %s mem_we cycle %0d: got %b expected %b", name, c, s_we, exp_we[c]);
      end
      checks++;
      if (s_halted !== hexp) begin
        errors++; $display("[TB] FAIL %s halted cycle %0d: got %b expected %b", name, c, s_halted, hexp);
      end
      checks++;
      if (s_illegal !== (hexp && exp_ill)) begin
        errors++; $display("[TB] FAIL %s illegal cycle %0d: got %b expected %b", name, c, s_illegal, hexp && exp_ill);
      end
      checks++;
      if (s_aluop !== exp_aluop[c]) begin
        errors++; $display("[TB] FAIL %s alu_opcode cycle %0d: got %h expected %h", name, c, s_aluop, exp_aluop[c]);
      end
      if (exp_fetch[c]) begin
        checks++;
        if (s_addr !== {4'h0, exp_fetch_addr[c]}) begin
          errors++; $display("[TB] FAIL %s fetch mem_addr cycle %0d: got %h expected %h", name, c, s_addr, exp_fetch_addr[c]);
        end
      end
      if (exp_we[c]) begin
        checks++;
        if (s_addr !== exp_we_addr[c] || s_wdata !== exp_we_data[c]) begin
          errors++; $display("[TB] FAIL %s store cycle %0d: got %h<=%h expected %h<=%h", name, c, s_addr, s_wdata, exp_we_addr[c], exp_we_data[c]);
        end
      end
      if (c > 0 && exp_done[c-1]) begin
        checks++;
        if (s_pc !== exp_pc[c-1] || s_ac !== exp_ac[c-1]) begin
          errors++; $display("[TB] FAIL %s retire state cycle %0d: got pc %h ac %h expected pc %h ac %h", name, c, s_pc, s_ac, exp_pc[c-1], exp_ac[c-1]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (obs_retires != exp_retires) begin
      errors++; $display("[TB] FAIL %s retire count: got %0d expected %0d", name, obs_retires, exp_retires);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if ((which ? mem1[i] : mem0[i]) !== mm[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL %s memory image: %0d words differ, expected 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++; if (pc0 !== 12'h000) begin errors++; $display("[TB] FAIL reset pc0: got %h expected 000", pc0); end
    checks++; if (pc1 !== 12'hFFF) begin errors++; $display("[TB] FAIL reset pc1: got %h expected fff", pc1); end
    checks++; if (ir0 !== 16'h0 || ir1 !== 16'h0) begin errors++; $display("[TB] FAIL reset ir: got %h/%h expected 0000", ir0, ir1); end
    checks++; if (ac0 !== 16'h0) begin errors++; $display("[TB] FAIL reset ac: got %h expected 0000", ac0); end
    checks++; if (done0 !== 1'b0 || halted0 !== 1'b0 || illegal0 !== 1'b0) begin errors++; $display("[TB] FAIL reset flags: got %b%b%b expected 000", done0, halted0, illegal0); end
    checks++; if (bus0.mem_we !== 1'b0 || bus0.alu_opcode !== 4'h0) begin errors++; $display("[TB] FAIL reset we/aluop: got %b/%h expected 0/0", bus0.mem_we, bus0.alu_opcode); end
    checks++; if (bus0.mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset mem_addr0: got %h expected 0000", bus0.mem_addr); end
    checks++; if (bus1.mem_addr !== 16'h0FFF) begin errors++; $display("[TB] FAIL reset mem_addr1: got %h expected 0fff", bus1.mem_addr); end
  endtask

  task automatic test_reset_mid_store;
    bit seen;
    clear_prog;
    prog[0] = 16'h1010; prog[1] = 16'h2020; prog[2] = 16'h0000; prog[16'h10] = 16'h1234;
    load_and_release(1'b0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (s_we === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL mid_store wait: got no mem_we within 20 cycles, expected one");
    end else begin
      reset = 1'b1;
      #1;
      checks++; if (s_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_store async we: got %b expected 0", s_we); end
      checks++; if (s_pc !== 12'h000 || s_ac !== 16'h0) begin errors++; $display("[TB] FAIL mid_store regs: got pc %h ac %h expected 000 0000", s_pc, s_ac); end
      @(posedge clk);
      #1;
      checks++; if (mem0[16'h20] !== 16'h0000) begin errors++; $display("[TB] FAIL mid_store memory: got %h expected 0000", mem0[16'h20]); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (s_addr !== 16'h0000 || s_halted !== 1'b0) begin errors++; $display("[TB] FAIL mid_store refetch: got addr %h halted %b expected 0000 0", s_addr, s_halted); end
    end
  endtask

  task automatic test_program_example;
    clear_prog;
    prog[0] = 16'h1010; prog[1] = 16'h3011; prog[2] = 16'h2012; prog[3] = 16'h0000;
    prog[16'h10] = 16'h0005; prog[16'h11] = 16'h0003;
    run_and_check(1'b0, 12'h000, 30, "example");
    checks++; if (mem0[16'h12] !== 16'h0008) begin errors++; $display("[TB] FAIL example result: got %h expected 0008", mem0[16'h12]); end
    checks++; if (obs_halt_cycle != 17) begin errors++; $display("[TB] FAIL example halt cycle: got %0d expected 17", obs_halt_cycle); end
    checks++; if (obs_retires != 4) begin errors++; $display("[TB] FAIL example done pulses: got %0d expected 4", obs_retires); end
  endtask

  task automatic test_jz;
    clear_prog;
    prog[0] = 16'h5020;
    run_and_check(1'b0, 12'h000, 12, "jz_taken");
    checks++; if (obs_addr[3] !== 16'h0020 || obs_done[2] !== 1'b1) begin errors++; $display("[TB] FAIL jz_taken: got addr %h done %b expected 0020 1", obs_addr[3], obs_done[2]); end
    clear_prog;
    prog[0] = 16'h1030; prog[1] = 16'h5020; prog[16'h30] = 16'h0001;
    run_and_check(1'b0, 12'h000, 16, "jz_not_taken");
    checks++; if (obs_addr[8] !== 16'h0002 || obs_done[7] !== 1'b1) begin errors++; $display("[TB] FAIL jz_not_taken: got addr %h done %b expected 0002 1", obs_addr[8], obs_done[7]); end
  endtask

  task automatic test_pc_wrap;
    clear_prog;
    prog[12'hFFF] = 16'h4005;
    run_and_check(1'b1, 12'hFFF, 12, "pc_wrap");
    checks++; if (obs_pc[2] !== 12'h000) begin errors++; $display("[TB] FAIL pc_wrap wrapped pc: got %h expected 000", obs_pc[2]); end
    checks++; if (obs_addr[3] !== 16'h0005) begin errors++; $display("[TB] FAIL pc_wrap target: got %h expected 0005", obs_addr[3]); end
  endtask

  task automatic test_illegal;
    clear_prog;
    prog[0] = 16'h7000;
    run_and_check(1'b0, 12'h000, 40, "illegal");
    checks++; if (obs_pc[39] !== 12'h001 || obs_we_count != 0) begin errors++; $display("[TB] FAIL illegal hold: got pc %h writes %0d expected 001 0", obs_pc[39], obs_we_count); end
    checks++; if (s_illegal !== 1'b1 || s_halted !== 1'b1) begin errors++; $display("[TB] FAIL illegal flags: got %b%b expected 11", s_illegal, s_halted); end
  endtask

  task automatic test_alu_equal;
    clear_prog;
    prog[0] = 16'h1010; prog[1] = 16'h3F11; prog[2] = 16'h2012; prog[3] = 16'h0000;
    prog[16'h10] = 16'h1234; prog[16'h11] = 16'h1234;
    run_and_check(1'b0, 12'h000, 25, "alu_equal");
    checks++; if (mem0[16'h12] !== 16'h0001) begin errors++; $display("[TB] FAIL alu_equal result: got %h expected 0001", mem0[16'h12]); end
    checks++; if (obs_aluop[8] !== 4'h0 || obs_aluop[9] !== 4'hF || obs_aluop[10] !== 4'h0) begin errors++; $display("[TB] FAIL alu_equal opcode window: got %h %h %h expected 0 f 0", obs_aluop[8], obs_aluop[9], obs_aluop[10]); end
  endtask

  task automatic test_random;
    int r;
    logic [7:0] d;
    for (int round = 0; round < 6; round++) begin
      clear_prog;
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 99));
        d = 8'h40 + 8'($urandom_range(0, 15));
        if (r < 25)      prog[i] = {4'h1, 4'h0, d};
        else if (r < 45) prog[i] = {4'h2, 4'h0, d};
        else if (r < 70) prog[i] = {4'h3, 4'($urandom_range(0, 15)), d};
        else if (r < 80) prog[i] = {4'h5, 12'($urandom_range(0, 16))};
        else if (r < 88) prog[i] = {4'h4, 12'($urandom_range(0, 16))};
        else if (r < 94) prog[i] = {4'h1, 12'($urandom_range(0, 15))};
        else if (r < 98) prog[i] = {4'h2, 12'($urandom_range(0, 16))};
        else             prog[i] = {4'($urandom_range(6, 15)), 12'h000};
      end
      for (int i = 16'h40; i < 16'h50; i++)
        prog[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_and_check(1'b0, 12'h000, 500, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    test_reset;
    test_reset_mid_store;
    test_program_example;
    test_jz;
    test_pc_wrap;
    test_illegal;
    test_alu_equal;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_execute_sequencer.md
# fetch_execute_sequencer

Multi-cycle fetch/decode/execute controller that drives the 16-bit accumulator datapath. It sequences the single-port main memory through instruction fetch, operand read and store. It feeds operands and a 4-bit operation code to the combinational ALU and latches the ALU result into the accumulator. It owns the architectural PC, IR and AC registers and sits between main memory (upstream) and the ALU (downstream).

## Interface
- RESET_PC, 12'h000, PC value loaded on reset.

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- mem_addr  out  16  memory address; zero-extended 12-bit address
- mem_we  out  1  memory write enable
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid the cycle after the address is presented with mem_we=0
- alu_opcode  out  4  ALU operation select
- alu_a  out  16  ALU operand 1 (always AC)
- alu_b  out  16  ALU operand 2 (always mem_rdata)
- alu_result  in  16  combinational ALU result
- pc_out / ir_out / ac_out  out  12/16/16  architectural registers, for debug
- instr_done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  high in HALT state
- illegal  out  1  sticky; set when an undefined opcode is decoded

## Operation
- Instruction format: op=ir[15:12], addr=ir[11:0]. For ALU instructions, alu_op=ir[11:8] and addr={4'h0, ir[7:0]}.
- Opcodes: 0 HALT; 1 LOAD (AC<=M[addr]); 2 STORE (M[addr]<=AC); 3 ALU (AC<=alu_result of AC op M[addr]); 4 JUMP (PC<=addr); 5 JZ (PC<=addr if AC==16'h0000); 6–F illegal.
- States:
  - FETCH: mem_addr=PC, we=0. Next FWAIT.
  - FWAIT: IR<=mem_rdata; PC<=PC+1, wrapping 12'hFFF->12'h000. Next DECODE.
  - DECODE:
    - HALT -> HALT.
    - LOAD/ALU -> RD.
    - STORE -> WR.
    - JUMP -> PC<=addr, done, FETCH.
    - JZ -> conditional PC load using AC as held in DECODE, done, FETCH.
    - Illegal -> illegal<=1, HALT.
  - RD: mem_addr=addr, we=0. Next EXEC.
  - EXEC: LOAD: AC<=mem_rdata. ALU: alu_opcode=alu_op, AC<=alu_result. Both pulse done and go to FETCH.
  - WR: mem_addr=addr, mem_we=1, mem_wdata=AC, done. Next FETCH.
  - HALT: absorbing; only reset exits. No memory writes.
- All memory/ALU outputs are Moore decodes of state and registers only; no combinational path from mem_rdata or alu_result to any output except alu_b.
- Outside EXEC, alu_opcode=4'h0. mem_wdata=AC in all states, but is qualified only by mem_we.
- Arithmetic is 16-bit modulo; the sequencer never inspects ALU results. Division by zero is the ALU's behaviour, latched as-is.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, IR=0, AC=0, illegal=0, halted=0, instr_done=0, mem_we=0. mem_addr={4'h0,RESET_PC}.
- Cycles per instruction, FETCH through retire:
  - LOAD/ALU 5
  - STORE 4
  - JUMP/JZ 3 (taken or not)
  - HALT 3, then halted=1 from the 4th cycle onward
- instr_done is asserted during the final state cycle: EXEC, WR, or DECODE for jumps. AC/PC updates are visible the cycle after.
- mem_we is high for exactly one cycle per STORE; never in any other state.
- Reset asserted mid-instruction (including during WR) drops mem_we in the same cycle, asynchronously. The partial instruction is abandoned with no AC/PC commit.
- Reset release: the first fetch address is presented in the first clock cycle after deassertion.
- Self-modifying code: a STORE to PC's next address is fetched correctly, since the write completes before the next FETCH.

## Test plan
- Reset mid-STORE (assert during WR) -> mem_we=0 immediately; after release, PC=0, AC=0, first fetch at address 0.
- Program at 0: LOAD 0x010 (M=0x0005); ALU op 0 addr 0x11 (M=0x0003); STORE 0x012; HALT. Required response:
  - M[0x012]=0x0008.
  - halted=1 at cycle 17.
  - Four instr_done pulses.
- JZ coverage:
  - AC=0, JZ 0x020 -> next fetch address 0x020.
  - AC=0x0001, same instruction -> next fetch at PC+1.
  - Both cases take 3 cycles.
- PC wrap: RESET_PC=12'hFFF with M[0xFFF]=JUMP 0x005 -> PC passes through 0x000, then fetch at 0x005.
- Opcode 4'h7 at address 0 -> illegal=1, halted=1. mem_we stays 0 forever and PC=0x001 holds.
- ALU op 4'hF (equal) with AC=0x1234 and M=0x1234 -> AC=0x0001, alu_opcode=4'hF only during the EXEC cycle.
